// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
package sipo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sipo_fifo2.sv
// Two-entry first-in first-out word buffer; a push while full is dropped unless a pop
// happens on the same edge.
module sipo_fifo2
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = din;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = din;
        end else if (push) begin
          tail_d  = din;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: a push is only taken when the head leaves on the same edge.
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = din;
          end else begin
            count_d = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/sipo_receiver.sv
// Frames serial bits from an upstream PISO stage into WIDTH-bit words and queues them
// in a two-entry buffer, flagging short frames and dropped words.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             select,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             frame_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] shifted;
  logic             frame_err_q, frame_err_d;
  logic             overflow_q, overflow_d;
  logic             sample, push, pop, full, empty;

  assign sample = enable && select && (state_q == IDLE || state_q == SHIFT);
  assign push   = sample && (state_q == SHIFT) && (cnt_q == LAST);
  assign pop    = out_ready && !empty;

  // After WIDTH shifts the first bit lands in bit 0 (LSB_FIRST) or bit WIDTH-1.
  always_comb begin
    if (LSB_FIRST) shifted = {serial_in, part_q[WIDTH-1:1]};
    else           shifted = {part_q[WIDTH-2:0], serial_in};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    part_d      = part_q;
    frame_err_d = 1'b0;
    overflow_d  = overflow_q || (push && full && !pop);
    case (state_q)
      IDLE: begin
        if (sample) begin
          part_d  = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sample) begin
          if (cnt_q == LAST) begin
            part_d  = '0;
            cnt_d   = '0;
            state_d = WAIT;
          end else begin
            part_d = shifted;
            cnt_d  = cnt_q + 1'b1;
          end
        end else if (enable && !select) begin
          part_d      = '0;
          cnt_d       = '0;
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      WAIT: begin
        if (enable && !select) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      part_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sipo_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (shifted),
    .dout (data_out),
    .full (full),
    .empty(empty)
  );

  assign out_valid = !empty;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: an LSB-first and an MSB-first instance share stimulus.
module tb_sipo_receiver;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset, enable, select, serial_in, out_ready;
  logic [W-1:0] data_out0, data_out1;
  logic         out_valid0, out_valid1, overflow0, overflow1, frame_err0, frame_err1;

  int           checks = 0;
  int           passes = 0;
  int           fe_cnt = 0;
  logic [W-1:0] got[$];

  always #5 clk = ~clk;

  sipo_receiver #(.WIDTH(W), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .select(select), .serial_in(serial_in),
    .data_out(data_out0), .out_valid(out_valid0), .out_ready(out_ready),
    .overflow(overflow0), .frame_err(frame_err0)
  );

  sipo_receiver #(.WIDTH(W), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .select(select), .serial_in(serial_in),
    .data_out(data_out1), .out_valid(out_valid1), .out_ready(out_ready),
    .overflow(overflow1), .frame_err(frame_err1)
  );

  // Records every word the consumer accepts from the LSB-first instance.
  always @(negedge clk) begin
    if (reset && out_valid0 && out_ready) got.push_back(data_out0);
    if (frame_err0) fe_cnt++;
  end

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; select = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    got.delete();
    fe_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    enable = 1'b1; select = 1'b1; serial_in = b;
    @(posedge clk); #1;
  endtask

  task automatic gap();
    enable = 1'b1; select = 1'b0; serial_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(w[i]);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0)
      $display("FAIL reset_valid: got %b/%b want 0/0", out_valid0, out_valid1); else passes++;
    checks++; if (data_out0 !== 4'h0 || data_out1 !== 4'h0)
      $display("FAIL reset_data: got %h/%h want 0/0", data_out0, data_out1); else passes++;
    checks++; if (overflow0 !== 1'b0 || frame_err0 !== 1'b0)
      $display("FAIL reset_flags: got ovf=%b ferr=%b want 0/0", overflow0, frame_err0);
    else passes++;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    send_word(4'b0001);
    checks++; if (out_valid0 !== 1'b1 || data_out0 !== 4'b0001)
      $display("FAIL single_latency: got v=%b d=%b want v=1 d=0001", out_valid0, data_out0);
    else passes++;
    gap();
    checks++; if (out_valid0 !== 1'b0)
      $display("FAIL single_pop: got valid=%b want 0", out_valid0); else passes++;
    gap();
    checks++; if (got.size() != 1 || got[0] !== 4'b0001)
      $display("FAIL single_word: got n=%0d w0=%b want n=1 w0=0001", got.size(),
               (got.size() > 0) ? got[0] : 4'hx);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp [5] = '{4'b0011, 4'b1011, 4'b1010, 4'b1000, 4'b0111};
    do_reset();
    out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      send_word(exp[f]);
      gap();
    end
    gap();
    checks++; if (got.size() != 5)
      $display("FAIL b2b_count: got %0d want 5", got.size()); else passes++;
    for (int f = 0; f < 5; f++) begin
      if (f < got.size()) begin
        checks++; if (got[f] !== exp[f])
          $display("FAIL b2b_word%0d: got %b want %b", f, got[f], exp[f]); else passes++;
      end
    end
    checks++; if (overflow0 !== 1'b0 || fe_cnt != 0)
      $display("FAIL b2b_flags: got ovf=%b ferr=%0d want 0/0", overflow0, fe_cnt);
    else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(4'b0011); gap();
    send_word(4'b1011); gap();
    checks++; if (overflow0 !== 1'b0 || data_out0 !== 4'b0011)
      $display("FAIL ovf_full: got ovf=%b d=%b want 0/0011", overflow0, data_out0); else passes++;
    send_word(4'b0110); gap();
    checks++; if (overflow0 !== 1'b1 || data_out0 !== 4'b0011)
      $display("FAIL ovf_drop: got ovf=%b d=%b want 1/0011", overflow0, data_out0); else passes++;
    out_ready = 1'b1;
    repeat (3) gap();
    checks++; if (got.size() != 2 || got[0] !== 4'b0011 || got[1] !== 4'b1011)
      $display("FAIL ovf_drain: got n=%0d want 0011,1011", got.size()); else passes++;
    checks++; if (overflow0 !== 1'b1 || out_valid0 !== 1'b0)
      $display("FAIL ovf_sticky: got ovf=%b v=%b want 1/0", overflow0, out_valid0); else passes++;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    send_word(4'b0101); gap();
    send_word(4'b1100); gap();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    out_ready = 1'b1;
    send_bit(1'b1);  // word 1110 arrives on the same edge 0101 leaves
    out_ready = 1'b0;
    checks++; if (overflow0 !== 1'b0 || data_out0 !== 4'b1100 || out_valid0 !== 1'b1)
      $display("FAIL pushpop_full: got ovf=%b d=%b v=%b want 0/1100/1", overflow0, data_out0,
               out_valid0);
    else passes++;
    out_ready = 1'b1;
    repeat (3) gap();
    checks++; if (got.size() != 3 || got[0] !== 4'b0101 || got[1] !== 4'b1100 ||
                  got[2] !== 4'b1110)
      $display("FAIL pushpop_order: got n=%0d want 0101,1100,1110", got.size());
    else passes++;
  endtask

  task automatic test_frame_err();
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0);
    gap();
    checks++; if (frame_err0 !== 1'b1 || out_valid0 !== 1'b0)
      $display("FAIL ferr_pulse: got ferr=%b v=%b want 1/0", frame_err0, out_valid0);
    else passes++;
    send_bit(1'b0);
    checks++; if (frame_err0 !== 1'b0)
      $display("FAIL ferr_one_cycle: got %b want 0", frame_err0); else passes++;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    gap(); gap();
    checks++; if (got.size() != 1 || got[0] !== 4'b1010 || fe_cnt != 1)
      $display("FAIL ferr_recover: got n=%0d ferr_cnt=%0d want n=1 (1010) cnt=1", got.size(),
               fe_cnt);
    else passes++;
  endtask

  task automatic test_enable_hold();
    do_reset();
    send_bit(1'b1); send_bit(1'b0);
    enable = 1'b0; select = 1'b1; serial_in = 1'b0;
    @(posedge clk); #1;
    select = 1'b0; serial_in = 1'b1;
    @(posedge clk); #1;
    select = 1'b1; serial_in = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid0 !== 1'b0 || frame_err0 !== 1'b0 || fe_cnt != 0)
      $display("FAIL hold_idle: got v=%b ferr=%b cnt=%0d want 0/0/0", out_valid0, frame_err0,
               fe_cnt);
    else passes++;
    send_bit(1'b1); send_bit(1'b1);
    checks++; if (out_valid0 !== 1'b1 || data_out0 !== 4'b1101)
      $display("FAIL hold_lsb: got v=%b d=%b want 1/1101", out_valid0, data_out0); else passes++;
    checks++; if (out_valid1 !== 1'b1 || data_out1 !== 4'b1011)
      $display("FAIL hold_msb: got v=%b d=%b want 1/1011", out_valid1, data_out1); else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_word(4'b0011); gap();
    send_bit(1'b1); send_bit(1'b1);
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid0 !== 1'b0 || data_out0 !== 4'h0 || out_valid1 !== 1'b0)
      $display("FAIL rst_async: got v=%b d=%h v1=%b want 0/0/0", out_valid0, data_out0,
               out_valid1);
    else passes++;
    @(posedge clk); #1 reset = 1'b1;
    got.delete();
    out_ready = 1'b1;
    send_word(4'b0110); gap(); gap();
    checks++; if (got.size() != 1 || got[0] !== 4'b0110 || fe_cnt != 0)
      $display("FAIL rst_recover: got n=%0d ferr_cnt=%0d want n=1 (0110) cnt=0", got.size(),
               fe_cnt);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_frame_err();
    test_enable_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter WIDTH, default 4: bits per word; legal range 2..16.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received bit is word bit 0; 0 = first received bit is word bit WIDTH-1.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 enable  input  1  bit-sample qualifier; when 0, all receive state holds.
REQ-006 select  input  1  frame gate from upstream PISO stage: 1 = shift phase (bits valid), 0 = load gap (frame boundary).
REQ-007 serial_in  input  1  serial bit from upstream PISO out.
REQ-008 data_out  output  WIDTH  head word of output buffer.
REQ-009 out_valid  output  1  data_out holds a valid word.
REQ-010 out_ready  input  1  consumer accepts head word when out_valid=1.
REQ-011 overflow  output  1  sticky: a completed word was dropped.
REQ-012 frame_err  output  1  one-cycle pulse: frame ended short.

Function
REQ-013 Bit sampled on a rising edge only when enable=1 and select=1 and FSM is IDLE or SHIFT.
REQ-014 FSM states IDLE, SHIFT, WAIT; bit counter cnt, 0..WIDTH-1.
REQ-015 IDLE: sample -> store bit, cnt=1, go SHIFT; otherwise stay.
REQ-016 SHIFT: sample with cnt<WIDTH-1 -> store bit, cnt+1; sample with cnt=WIDTH-1 -> assemble word, push to buffer, cnt=0, go WAIT.
REQ-017 SHIFT with enable=1 and select=0 -> discard partial word, cnt=0, pulse frame_err for one cycle, go IDLE.
REQ-018 WAIT: ignore serial_in (bits after the WIDTH-th are padding); on enable=1 and select=0 go IDLE.
REQ-019 enable=0 in any state holds state, cnt, and partial word; frame_err not raised.
REQ-020 Word assembly honours LSB_FIRST; e.g. WIDTH=4, LSB_FIRST=1, bits 1,1,0,1 -> 4'b1011.
REQ-021 Output buffer 2 entries, first-in first-out; pop when out_valid=1 and out_ready=1.
REQ-022 Latency: pushed word into empty buffer shows out_valid=1 and data_out in the cycle after the edge sampling its last bit.
REQ-023 data_out stable while out_valid=1 and out_ready=0.
REQ-024 Push and pop same edge with buffer full: both occur, no overflow.
REQ-025 Push with buffer full and no pop: word dropped, buffer unchanged, overflow set and held until reset.
REQ-026 Pop with buffer empty: no effect.

Reset
REQ-027 reset=0 asynchronously forces FSM=IDLE, cnt=0, partial word=0, buffer empty, data_out=0, out_valid=0, overflow=0, frame_err=0.
REQ-028 reset mid-frame discards the partial word and all buffered words; no frame_err pulse.
REQ-029 Reset release sampled synchronously; first bit may be taken on the first rising edge after release.

Structure
REQ-030 Shared package sipo_pkg holds the FSM state type (IDLE, SHIFT, WAIT) and default WIDTH constant (4).
REQ-031 Output buffer is a sub-module sipo_fifo2 (2-entry, WIDTH-parameterised, push/pop/full/empty).

Verification
REQ-032 PISO loads 4'b0001, four select=1 cycles, out_ready=1 -> one word 4'b0001, out_valid one cycle.
REQ-033 Back-to-back frames 4'b0011, 4'b1011, 4'b1010, 4'b1000, 4'b0111 (one-cycle select=0 gaps) -> same five words in order, overflow=0.
REQ-034 out_ready=0, three complete frames -> first two words retained, third dropped, overflow=1; then out_ready=1 -> 4'b0011 then 4'b1011.
REQ-035 select falls after 2 bits -> frame_err one-cycle pulse, no word pushed; next full frame 4'b1010 received correctly.
REQ-036 enable=0 for 3 cycles mid-frame -> partial word held; completing frame yields correct word; LSB_FIRST=0 run, bits 1,0,1,1 -> 4'b1011.
REQ-037 reset=0 asserted after 2 bits with one word buffered -> out_valid=0 immediately (asynchronous), buffer empty, next frame received cleanly.
